// File: rtl/serial_add_sequencer_if.sv
// Operand/result handshake bundle for serial_add_sequencer.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  // Operand channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif

  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Producer/consumer side
  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output cin,
    input  out_valid,
    output out_ready,
    input  sum,
    input  cout
  );

  // Adder stage side
  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  cin,
    output out_valid,
    input  out_ready,
    output sum,
    output cout
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full-adder cell, registered carry, LSB-first over WIDTH clocks.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via ~b and carry-in of 1).
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_add_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH < 2) begin : g_width_check
    $error("serial_add_sequencer: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic bit_s;
  logic bit_c;
  logic last_bit;
  logic accept;
  logic sub_sel;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  // The full-adder bit cell and handshake decode.
  always_comb begin
    bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c    = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // in_ready_q is only ever high in IDLE, but it stays low for the first
    // cycle out of reset, so it gates acceptance as well.
    accept   = (state_q == ST_IDLE) && in_ready_q && bus.in_valid;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = sub_sel ? ~bus.b : bus.b;
          carry_d = sub_sel ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        acc_d   = {bit_s, acc_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_c;
        cnt_d   = cnt_q + CNT_W'(1);
        // Publish only the completed word so sum never shows partial bits.
        if (last_bit) begin
          sum_d   = acc_d;
          cout_d  = bit_c;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // NOTE: the datapath registers take the async reset too, because a reset
  // must abort the operation and clear the visible sum/cout immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cout_q     <= cout_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench: directed cases, randomized operands with random backpressure
// against an arithmetic reference model, plus an exhaustive WIDTH=2 sweep.
module tb_serial_add_sequencer;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  serial_add_sequencer_if #(.WIDTH(8)) bus8 ();
  serial_add_sequencer_if #(.WIDTH(2)) bus2 ();

  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_add_sequencer #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result of the operation as plain integer arithmetic.
  function automatic logic [31:0] ref_result(input int unsigned a, input int unsigned b,
                                             input bit cin, input bit sub, input int w);
    int unsigned mask;
    int unsigned total;
    mask = (32'd1 << w) - 1;
    if (sub) begin
      // cout = 1 means no borrow
      return {(a >= b) ? 32'd1 : 32'd0} << w | ((a - b) & mask);
    end
    total = a + b + (cin ? 1 : 0);
    return total & ((mask << 1) | 1);
  endfunction

  task automatic drive_operands8(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input bit sub);
    bus8.a   = a;
    bus8.b   = b;
    bus8.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = sub;
`else
    if (sub) $display("sub requested without SERIAL_ADD_SUB_EN; ignored");
`endif
  endtask

  // Present operands at a negedge, wait (bounded) for in_ready, pass the accept edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input bit sub);
    int k;
    drive_operands8(a, b, cin, sub);
    bus8.in_valid = 1'b1;
    k = 0;
    while (!bus8.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", bus8.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  // Called at the negedge after the accept edge; measures latency and checks the result.
  task automatic finish_op8(input logic [31:0] exp, input string tag);
    int lat;
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_busy_ready"}, bus8.in_ready, 1'b0);
    end
    check({tag, "_out_valid"}, bus8.out_valid, 1'b1);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_result"}, {23'd0, bus8.cout, bus8.sum}, exp);
    if (bus8.out_ready) begin
      @(negedge clk);
      check({tag, "_consumed"}, {bus8.out_valid, bus8.in_ready}, 2'b01);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input bit sub, input string tag);
    start_op8(a, b, cin, sub);
    finish_op8(ref_result(a, b, cin, sub, 8), tag);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rcin;
    bit         rsub;
    int         bp;
    logic [8:0] held;

    rst_n          = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b1;
    bus2.a         = '0;
    bus2.b         = '0;
    bus2.cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus2.sub       = 1'b0;
`endif
    drive_operands8(8'h00, 8'h00, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus8.in_ready, 1'b0);
    check("rst_outputs", {bus8.out_valid, bus8.cout, bus8.sum}, 10'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus8.in_ready, 1'b1);

    // Directed cases
    op8(8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");

    // Backpressure: result held, new operands refused until back in IDLE
    bus8.out_ready = 1'b0;
    start_op8(8'h3C, 8'h0F, 1'b0, 1'b0);
    finish_op8(ref_result(8'h3C, 8'h0F, 1'b0, 1'b0, 8), "bp_first");
    drive_operands8(8'h11, 8'h22, 1'b0, 1'b0);
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {bus8.out_valid, bus8.in_ready, bus8.cout, bus8.sum},
            {2'b10, 9'h04B});
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {bus8.out_valid, bus8.in_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    finish_op8(ref_result(8'h11, 8'h22, 1'b0, 1'b0, 8), "bp_second");

    // Reset during the 4th shift cycle aborts the operation
    start_op8(8'h55, 8'h66, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {bus8.out_valid, bus8.in_ready, bus8.cout, bus8.sum}, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_recover", {bus8.out_valid, bus8.in_ready}, 2'b01);
    op8(8'h12, 8'h34, 1'b0, 1'b0, "after_rst");

`ifdef SERIAL_ADD_SUB_EN
    op8(8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07");
    op8(8'h07, 8'h05, 1'b1, 1'b1, "sub_07_05");
`endif

    // Randomized operands with random backpressure
    for (int n = 0; n < 40; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rcin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      bp   = $urandom_range(0, 3);
      bus8.out_ready = (bp == 0);
      start_op8(ra, rb, rcin, rsub);
      finish_op8(ref_result(ra, rb, rcin, rsub, 8), "rand");
      if (bp != 0) begin
        held = ref_result(ra, rb, rcin, rsub, 8);
        repeat (bp) @(negedge clk);
        check("rand_hold", {bus8.out_valid, bus8.in_ready, bus8.cout, bus8.sum},
              {2'b10, held});
        bus8.out_ready = 1'b1;
        @(negedge clk);
        check("rand_release", {bus8.out_valid, bus8.in_ready}, 2'b01);
      end
    end

    // Exhaustive WIDTH=2 sweep
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int k;
          bus2.a        = 2'(ia);
          bus2.b        = 2'(ib);
          bus2.cin      = 1'(ic);
          bus2.in_valid = 1'b1;
          k = 0;
          while (!bus2.in_ready && k < 20) begin
            @(negedge clk);
            k++;
          end
          @(posedge clk);
          @(negedge clk);
          bus2.in_valid = 1'b0;
          k = 0;
          while (!bus2.out_valid && k < 20) begin
            @(negedge clk);
            k++;
          end
          check($sformatf("w2_%0d_%0d_%0d", ia, ib, ic),
                {bus2.out_valid, k[3:0], bus2.cout, bus2.sum},
                {1'b1, 4'd2, 3'(ia + ib + ic)});
          @(negedge clk);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Bit-serial adder stage that accepts two WIDTH-bit operands over a valid/ready handshake, adds them LSB-first through a single 1-bit full-adder cell with a registered carry, and presents the WIDTH-bit sum plus carry-out on an output handshake. It sits upstream of the full-adder bit cell, feeding it one bit per clock, and downstream of whatever produces operands. It trades latency for area against a ripple-carry array.

## Interface
- WIDTH, 8, operand and sum width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand word valid.
- in_ready  output  1  stage can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  initial carry-in.
- sub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  final carry-out.

## Operation
- Bit cell is a zero-delay combinational full adder:
  - s = a0 ^ b0 ^ c
  - c' = a0&b0 | (a0^b0)&c
- States:
  - IDLE: in_ready = 1.
    - On in_valid & in_ready: load A shift register with a and B shift register with b.
    - Load carry flop with cin, clear count, go to SHIFT.
  - SHIFT: each cycle, apply A[0], B[0] and the carry flop to the bit cell.
    - Shift the sum register right with s entering at the MSB.
    - Shift A and B right, carry ← c', count ← count + 1.
    - When count = WIDTH−1, go to DONE after this shift.
  - DONE: out_valid = 1; sum = sum register; cout = carry flop.
    - On out_ready, go to IDLE.
- Count is $clog2(WIDTH)+1 bits wide and never wraps within an operation.
- in_valid is ignored outside IDLE; a, b and cin are sampled only at the accept edge.
- sum and cout hold their last values in IDLE and SHIFT; they are updated only at the final shift.
  - Use a separate result register so sum does not show partial values.
- No same-cycle pass-through: in_ready is low in DONE, even when out_ready is high.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - out_valid = 0, sum = 0, cout = 0, all internal registers cleared.
  - in_ready = 0 while rst_n is low, 1 from the first cycle after deassertion.
- Reset asserted mid-SHIFT or in DONE aborts the operation; no result is ever emitted for it.

## Timing
- Accept at edge E0; shifts on edges E1..EWIDTH; out_valid is high after edge EWIDTH.
- Latency is WIDTH cycles from accept to out_valid.
- With out_ready held high, the result is consumed at EWIDTH+1, and in_ready is high after that edge.
- Throughput is one operation per WIDTH+2 cycles.
- in_ready and out_valid decode directly from registered state (no input-to-output combinational path).
- out_valid stays high and sum/cout stay stable until the out_ready handshake (AXI-style hold).

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists and is sampled at accept.
  - If sub = 1, the B register loads ~b, the carry flop loads 1, and cin is ignored.
  - Result: sum = a − b mod 2^WIDTH; cout = 1 means no borrow.
  - If sub = 0, behaviour is addition.
- SERIAL_ADD_SUB_EN undefined: no sub port; addition only.

## Test plan
- WIDTH=8, a=0x7F, b=0x01, cin=0, out_ready=1 → out_valid rises exactly 8 cycles after accept; sum=0x80, cout=0; in_ready returns one cycle later.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 back-to-back → sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands → sum/cout stable, in_ready=0, new operands not taken. Raise out_ready → accept occurs only after return to IDLE.
- Reset mid-operation: assert rst_n=0 at the 4th SHIFT cycle → out_valid=0, sum=0, cout=0 immediately. After release, a=0x12, b=0x34 → sum=0x46, cout=0.
- With SERIAL_ADD_SUB_EN: a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0. Then a=0x07, b=0x05, sub=1 → sum=0x02, cout=1.
- Exhaustive WIDTH=2 sweep of all a, b, cin (32 cases) against a+b+cin → every {cout,sum} matches.
